// File: rtl/mux4_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4:1 word mux feeding the write bus.
// Latency: grant one cycle after a request seen in IDLE; dout/dout_valid registered one cycle after each beat.
// Backpressure: ready=0 stalls the granted requester in place; the grant is held with no timeout.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   req[3:0]            per-requester request, held while din<i> carries data
//   din0..din3          requester data words
//   ready               downstream accepts a beat this cycle
//   gnt[3:0], sel[1:0]  registered one-hot grant and matching mux select
//   dout, dout_valid    registered transferred word and its valid pulse
//   busy                high while a grant is active
module mux4_bus_arbiter #(
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] din0,
   input  logic [WIDTH-1:0] din1,
   input  logic [WIDTH-1:0] din2,
   input  logic [WIDTH-1:0] din3,
   input  logic             ready,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   state_t           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       last_q, last_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dv_q, dv_d;

   logic [WIDTH-1:0] mux_dat;
   logic             pick_vld;
   logic [1:0]       pick_idx;
   logic [1:0]       cand;
   logic [3:0]       cnt_inc;
   logic             beat;

   // Shared datapath mux, steered by the registered select.
   always_comb begin
      case (sel_q)
         2'd0:    mux_dat = din0;
         2'd1:    mux_dat = din1;
         2'd2:    mux_dat = din2;
         default: mux_dat = din3;
      endcase
   end

   // Round-robin search starting just after the last grant; k=4 wraps back to
   // last itself, so the most recently served requester is checked last.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = last_q;
      cand     = last_q;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign beat    = req[sel_q] && ready;
   assign cnt_inc = cnt_q + 4'd1;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_d = 4'b0000;
            if (pick_vld) begin
               gnt_d   = 4'b0001 << pick_idx;
               sel_d   = pick_idx;
               last_d  = pick_idx;
               cnt_d   = 4'd0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (beat) begin
               dout_d = mux_dat;
               dv_d   = 1'b1;
               cnt_d  = cnt_inc;
               // The final beat of a burst still transfers; release happens on the same edge.
               if (cnt_inc == MAX_B) begin
                  gnt_d   = 4'b0000;
                  state_d = IDLE;
               end
            end else if (!req[sel_q]) begin
               gnt_d   = 4'b0000;
               state_d = IDLE;
            end
         end
         default: begin
            gnt_d   = 4'b0000;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         last_q  <= 2'd3;
         cnt_q   <= 4'd0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
      end
   end

   assign gnt        = gnt_q;
   assign sel        = sel_q;
   assign dout       = dout_q;
   assign dout_valid = dv_q;
   assign busy       = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Bench for mux4_bus_arbiter: directed stimulus with a scoreboard of expected grants and beats.
// Latency: monitor samples on the falling edge; stimulus changes 1 ns after the rising edge.
// Backpressure: ready is driven low in the stall scenario to hold a grant.
module tb_mux4_bus_arbiter;

   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_0001;
   localparam logic [31:0] D2 = 32'hDEAD_BEEF;
   localparam logic [31:0] D3 = 32'h3333_0003;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] din0, din1, din2, din3;
   logic        ready;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic [31:0] dout;
   logic        dout_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_dat[$];
   int          exp_gnt[$];
   logic [3:0]  prev_gnt = 4'b0000;
   logic [31:0] e_dat;
   int          e_idx;

   mux4_bus_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .din0       (din0),
      .din1       (din1),
      .din2       (din2),
      .din3       (din3),
      .ready      (ready),
      .gnt        (gnt),
      .sel        (sel),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_beats(input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) exp_dat.push_back(d);
   endtask

   task automatic chk_drained(input string name);
      chk({name, "_beats_left"}, exp_dat.size(), 0);
      chk({name, "_grants_left"}, exp_gnt.size(), 0);
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_gnt"}, {28'd0, gnt}, 0);
      chk({name, "_sel"}, {30'd0, sel}, 0);
      chk({name, "_dout"}, dout, 0);
      chk({name, "_dv"}, {31'd0, dout_valid}, 0);
      chk({name, "_busy"}, {31'd0, busy}, 0);
   endtask

   // Monitor: every dout_valid pulse consumes one expected word, every new
   // grant consumes one expected index and must follow a cycle with no grant.
   always @(negedge clk) begin
      if (dout_valid === 1'b1) begin
         if (exp_dat.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got dout %h expected no beat at %0t", dout, $time);
         end else begin
            e_dat = exp_dat.pop_front();
            chk("dout", dout, e_dat);
         end
      end
      if (gnt != 4'b0000 && gnt != prev_gnt) begin
         if (exp_gnt.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got gnt %b expected none at %0t", gnt, $time);
         end else begin
            e_idx = exp_gnt.pop_front();
            chk("gnt_onehot", {28'd0, gnt}, 32'(4'b0001 << e_idx));
            chk("sel", {30'd0, sel}, 32'(e_idx));
            chk("grant_gap", {28'd0, prev_gnt}, 0);
         end
      end
      prev_gnt = gnt;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      req   = 4'hF;
      ready = 1'b1;
      din0  = D0;
      din1  = D1;
      din2  = D2;
      din3  = D3;

      // Reset held for two edges with every requester asserting.
      tick(2);
      chk_reset_vals("reset");

      // Round robin with all requesters: 0,1,2,3,0, four beats each, one idle gap between.
      exp_gnt.push_back(0); push_beats(D0, 4);
      exp_gnt.push_back(1); push_beats(D1, 4);
      exp_gnt.push_back(2); push_beats(D2, 4);
      exp_gnt.push_back(3); push_beats(D3, 4);
      exp_gnt.push_back(0); push_beats(D0, 4);
      rst_n = 1'b1;
      tick(1);
      chk("rr_first_gnt", {28'd0, gnt}, 32'h1);
      tick(24);
      req = 4'h0;
      tick(2);
      chk_drained("rr");
      chk("rr_idle_busy", {31'd0, busy}, 0);

      // Single requester 2: burst of four, one-cycle release, re-grant to 2.
      exp_gnt.push_back(2); push_beats(D2, 4);
      exp_gnt.push_back(2); push_beats(D2, 4);
      req = 4'b0100;
      tick(1);
      chk("single_gnt", {28'd0, gnt}, 32'h4);
      chk("single_busy", {31'd0, busy}, 1);
      tick(4);
      chk("single_release_gnt", {28'd0, gnt}, 0);
      tick(5);
      req = 4'h0;
      tick(2);
      chk_drained("single");

      // Stall: requester 1, ready low for three cycles after beat 2.
      exp_gnt.push_back(1); push_beats(D1, 4);
      req = 4'b0010;
      tick(3);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("stall_gnt", {28'd0, gnt}, 32'h2);
         chk("stall_dv", {31'd0, dout_valid}, 0);
      end
      ready = 1'b1;
      tick(2);
      req = 4'h0;
      chk("stall_release_gnt", {28'd0, gnt}, 0);
      tick(2);
      chk_drained("stall");

      // Early drop: requester 3 leaves after two beats while requester 0 waits.
      exp_gnt.push_back(3); push_beats(D3, 2);
      exp_gnt.push_back(0);
      req = 4'b1001;
      tick(1);
      chk("drop_gnt3", {28'd0, gnt}, 32'h8);
      tick(2);
      req = 4'b0001;
      tick(1);
      chk("drop_gap_gnt", {28'd0, gnt}, 0);
      tick(1);
      chk("drop_gnt0", {28'd0, gnt}, 32'h1);
      req = 4'h0;
      tick(2);
      chk_drained("drop");

      // Reset mid-burst after beat 1 of requester 1; afterwards req=0110 must go to 1.
      exp_gnt.push_back(1); push_beats(D1, 1);
      req = 4'b0010;
      tick(2);
      rst_n = 1'b0;
      tick(1);
      chk_reset_vals("midrst");
      exp_gnt.push_back(1);
      req   = 4'b0110;
      rst_n = 1'b1;
      tick(1);
      chk("midrst_gnt", {28'd0, gnt}, 32'h2);
      chk("midrst_sel", {30'd0, sel}, 1);
      req = 4'h0;
      tick(2);
      chk_drained("midrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
